fir_unfolded_input_packer: RTL and testbench
============================================

// Module: fir_unfolded_input_packer
// PURPOSE
//  Serial-to-parallel front end for the 3-way unfolded FIR.
//  - Accepts one NB-bit sample per valid cycle on DIN/VIN.
//  - Packs three consecutive valid samples into one 3-lane word on DOUT0..DOUT2,
//    qualified by VOUT, in the lane format fir_unfolded consumes (DIN0..DIN2/VIN).
//  - Sits between a serial sample source and fir_unfolded.
//  - Lane 0 is the oldest sample of the group; lane 2 is the newest.
// PARAMETERS
//  NB     8   sample width in bits, two's complement; passed through unmodified
// PORTS
//  CLK    in   1      system clock, rising edge; the single clock of the block
//  RST_n  in   1      reset, asynchronous assertion, active-low
//  DIN    in   NB     serial input sample
//  VIN    in   1      DIN valid; one sample accepted per cycle with VIN=1
//  CLR    in   1      synchronous clear: discard the partial group, realign lane 0
//  DOUT0  out  NB     packed lane 0 (oldest sample)
//  DOUT1  out  NB     packed lane 1
//  DOUT2  out  NB     packed lane 2 (newest sample)
//  VOUT   out  1      one-cycle strobe: DOUT0..2 hold a new complete group
//  FILL   out  2      samples currently held in the partial group (0..2)
// BEHAVIOUR
//  Reset (RST_n=0, asynchronous):
//  - DOUT0=DOUT1=DOUT2=0, VOUT=0, FILL=0.
//  - Phase=P0; lane holding registers cleared.
//  Phase FSM (P0/P1/P2), advances only on accepted samples (VIN=1, CLR=0):
//  - P0 + VIN: hold0<=DIN; ->P1.
//  - P1 + VIN: hold1<=DIN; ->P2.
//  - P2 + VIN: DOUT0<=hold0, DOUT1<=hold1, DOUT2<=DIN, VOUT<=1; ->P0.
//  - VIN=0: phase and hold registers unchanged.
//    Gaps of any length are allowed between any two samples.
//  Latency:
//  - VOUT rises on the edge that accepts the 3rd sample (visible the following cycle).
//  - VOUT is high exactly one cycle per group; no back-to-back VOUT is possible
//    (minimum 3 cycles between strobes).
//  Output hold:
//  - DOUT0..2 are registered and change only when a group completes.
//  - Values hold between strobes; the sink samples them when VOUT=1.
//  FILL:
//  - Registered; equals the phase (P0=0, P1=1, P2=2).
//  CLR (synchronous, dominates VIN):
//  - Phase->P0, FILL->0, VOUT->0 on the next edge.
//  - DIN in the same cycle is discarded.
//  - DOUT0..2 keep their last completed group.
//  - CLR in P2 with VIN=1: no group is emitted.
//  Reset mid-group:
//  - The partial group is lost; the first post-reset sample is lane 0.
//  Arithmetic:
//  - None; samples are bit-exact copies, no sign extension or rounding.
// STRUCTURE
//  Shared package (fir_unfolded_pkg):
//  - NB default.
//  - Unfolding factor constant UF=3.
//  - Phase encoding localparams P0=2'd0, P1=2'd1, P2=2'd2.
//  Submodule:
//  - One natural sub-module, fir_lane_reg: NB-bit register with async active-low
//    clear and load enable.
//  - Used for hold0, hold1 and DOUT0..2.
//  Top level:
//  - Phase FSM, VOUT and FILL logic in the top module.
//  - The unreachable phase encoding 2'd3 recovers to P0 with no output.
// TESTING
//  1. Reset, then DIN=1,2,3 with VIN=1 on 3 consecutive cycles
//     -> one VOUT pulse; DOUT0=1, DOUT1=2, DOUT2=3; FILL sequence 1,2,0.
//  2. 9 back-to-back samples 10..18
//     -> VOUT every 3rd cycle; groups (10,11,12), (13,14,15), (16,17,18).
//  3. Samples 5,_,_,6,_,7 with VIN=0 gaps
//     -> a single VOUT after 7; DOUT=(5,6,7); DOUT stable during gaps.
//  4. Samples 1,2, then CLR=1 with VIN=1/DIN=9, then 4,5,6
//     -> no strobe for 1,2,9; next group (4,5,6); DOUT held from the prior group
//        until then.
//  5. Samples 1,2, RST_n pulsed low mid-cycle, then 7,8,9
//     -> outputs 0 immediately on reset; group (7,8,9).
//  6. DIN=-128, 127, -1 (NB=8)
//     -> DOUT0=8'h80, DOUT1=8'h7F, DOUT2=8'hFF, bit-exact.

Source files
------------

// File: rtl/fir_unfolded_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fir_unfolded_pkg                                             |
// | Description : Shared constants and types for the 3-way unfolded FIR.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fir_unfolded_pkg;

  // Default sample width (two's complement, passed through unmodified)
  localparam int NB_DEF = 8;

  // Unfolding factor: number of samples packed into one parallel word
  localparam int UF = 3;

  // Phase encoding: the phase equals the number of samples currently held
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;

  typedef enum logic [1:0] {
    PH_P0 = P0,
    PH_P1 = P1,
    PH_P2 = P2
  } phase_t;

endpackage : fir_unfolded_pkg
`default_nettype wire

// File: rtl/fir_lane_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_lane_reg                                                 |
// | Description : NB-bit lane register, async active-low clear, load enable.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_lane_reg
  import fir_unfolded_pkg::*;
#(
  parameter int NB = NB_DEF
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          i_ld,
  input  logic [NB-1:0] i_d,
  output logic [NB-1:0] o_q
);

  logic [NB-1:0] r_q;

  // Capture the lane value only when loaded; otherwise hold it
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : fir_lane_reg
`default_nettype wire

// File: rtl/fir_unfolded_input_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_unfolded_input_packer                                    |
// | Description : Serial-to-parallel front end: packs three consecutive valid  |
// |               samples into one 3-lane word (lane 0 oldest, lane 2 newest). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_unfolded_input_packer
  import fir_unfolded_pkg::*;
#(
  parameter int NB = NB_DEF
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic [NB-1:0] DIN,
  input  logic          VIN,
  input  logic          CLR,
  output logic [NB-1:0] DOUT0,
  output logic [NB-1:0] DOUT1,
  output logic [NB-1:0] DOUT2,
  output logic          VOUT,
  output logic [1:0]    FILL
);

  phase_t        r_state;
  phase_t        w_nxt;
  logic          w_ld0;
  logic          w_ld1;
  logic          w_ldo;
  logic          w_vout_nxt;
  logic          r_vout;
  logic [1:0]    r_fill;
  logic [NB-1:0] w_hold0;
  logic [NB-1:0] w_hold1;

  // Phase register plus the registered strobe and fill count
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= PH_P0;
      r_vout  <= 1'b0;
      r_fill  <= P0;
    end else begin
      r_state <= w_nxt;
      r_vout  <= w_vout_nxt;
      r_fill  <= w_nxt;
    end
  end

  // Next phase and lane load enables; CLR dominates and discards DIN
  always_comb begin
    w_nxt      = r_state;
    w_ld0      = 1'b0;
    w_ld1      = 1'b0;
    w_ldo      = 1'b0;
    w_vout_nxt = 1'b0;
    if (CLR) begin
      w_nxt = PH_P0;
    end else begin
      case (r_state)
        PH_P0: begin
          if (VIN) begin
            w_ld0 = 1'b1;
            w_nxt = PH_P1;
          end
        end
        PH_P1: begin
          if (VIN) begin
            w_ld1 = 1'b1;
            w_nxt = PH_P2;
          end
        end
        PH_P2: begin
          if (VIN) begin
            w_ldo      = 1'b1;
            w_vout_nxt = 1'b1;
            w_nxt      = PH_P0;
          end
        end
        // Unreachable encoding: realign to lane 0 without emitting a group
        default: begin
          w_nxt = PH_P0;
        end
      endcase
    end
  end

  fir_lane_reg #(.NB(NB)) u_hold0 (
    .CLK   (CLK),
    .RST_n (RST_n),
    .i_ld  (w_ld0),
    .i_d   (DIN),
    .o_q   (w_hold0)
  );

  fir_lane_reg #(.NB(NB)) u_hold1 (
    .CLK   (CLK),
    .RST_n (RST_n),
    .i_ld  (w_ld1),
    .i_d   (DIN),
    .o_q   (w_hold1)
  );

  // Output lanes update together when the third sample of a group arrives
  fir_lane_reg #(.NB(NB)) u_dout0 (
    .CLK   (CLK),
    .RST_n (RST_n),
    .i_ld  (w_ldo),
    .i_d   (w_hold0),
    .o_q   (DOUT0)
  );

  fir_lane_reg #(.NB(NB)) u_dout1 (
    .CLK   (CLK),
    .RST_n (RST_n),
    .i_ld  (w_ldo),
    .i_d   (w_hold1),
    .o_q   (DOUT1)
  );

  fir_lane_reg #(.NB(NB)) u_dout2 (
    .CLK   (CLK),
    .RST_n (RST_n),
    .i_ld  (w_ldo),
    .i_d   (DIN),
    .o_q   (DOUT2)
  );

  assign VOUT = r_vout;
  assign FILL = r_fill;

endmodule : fir_unfolded_input_packer
`default_nettype wire

// File: tb/tb_fir_unfolded_input_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fir_unfolded_input_packer                                 |
// | Description : Scoreboard bench for the serial-to-parallel input packer.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fir_unfolded_input_packer;

  localparam int NB = 8;

  typedef struct packed {
    logic [NB-1:0] l0;
    logic [NB-1:0] l1;
    logic [NB-1:0] l2;
  } grp_t;

  logic          CLK;
  logic          RST_n;
  logic [NB-1:0] DIN;
  logic          VIN;
  logic          CLR;
  logic [NB-1:0] DOUT0;
  logic [NB-1:0] DOUT1;
  logic [NB-1:0] DOUT2;
  logic          VOUT;
  logic [1:0]    FILL;

  fir_unfolded_input_packer #(.NB(NB)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .DIN   (DIN),
    .VIN   (VIN),
    .CLR   (CLR),
    .DOUT0 (DOUT0),
    .DOUT1 (DOUT1),
    .DOUT2 (DOUT2),
    .VOUT  (VOUT),
    .FILL  (FILL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: samples of the partial group, completed groups
  // awaiting the monitor, and what the outputs should show this cycle.
  logic [NB-1:0] m_part[$];
  grp_t          m_exp[$];
  grp_t          m_last;
  logic          m_vout;
  int            m_fill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, from the packing rules only
  task automatic model_edge(input logic v, input logic [NB-1:0] d, input logic c);
    grp_t g;
    m_vout = 1'b0;
    if (RST_n) begin
      if (c) begin
        m_part.delete();
      end else if (v) begin
        m_part.push_back(d);
        if (m_part.size() == 3) begin
          g.l0 = m_part[0];
          g.l1 = m_part[1];
          g.l2 = m_part[2];
          m_exp.push_back(g);
          m_last = g;
          m_vout = 1'b1;
          m_part.delete();
        end
      end
    end
    m_fill = m_part.size();
  endtask

  // Drive one cycle of input, starting and ending at posedge+1
  task automatic step(input logic v, input logic [NB-1:0] d, input logic c);
    VIN = v;
    DIN = d;
    CLR = c;
    @(posedge CLK);
    model_edge(v, d, c);
    #1;
  endtask

  // Pulse reset low mid-cycle and check the outputs clear immediately
  task automatic do_reset();
    #2;
    RST_n = 1'b0;
    m_part.delete();
    m_exp.delete();
    m_last = '0;
    m_vout = 1'b0;
    m_fill = 0;
    #1;
    chk("rst_dout0", 32'(DOUT0), 32'd0);
    chk("rst_dout1", 32'(DOUT1), 32'd0);
    chk("rst_dout2", 32'(DOUT2), 32'd0);
    chk("rst_vout",  32'(VOUT),  32'd0);
    chk("rst_fill",  32'(FILL),  32'd0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    RST_n = 1'b1;
  endtask

  // Monitor: every falling edge, compare strobe, fill and lanes; pop a group
  // from the scoreboard whenever the DUT presents one.
  always @(negedge CLK) begin
    grp_t g;
    chk("vout", 32'(VOUT), 32'(m_vout));
    chk("fill", 32'(FILL), 32'(m_fill));
    if (VOUT) begin
      if (m_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL vout_unexpected: got strobe expected none at %0t", $time);
      end else begin
        g = m_exp.pop_front();
        chk("grp_lane0", 32'(DOUT0), 32'(g.l0));
        chk("grp_lane1", 32'(DOUT1), 32'(g.l1));
        chk("grp_lane2", 32'(DOUT2), 32'(g.l2));
      end
    end else begin
      chk("hold_lane0", 32'(DOUT0), 32'(m_last.l0));
      chk("hold_lane1", 32'(DOUT1), 32'(m_last.l1));
      chk("hold_lane2", 32'(DOUT2), 32'(m_last.l2));
    end
  end

  initial begin
    m_last = '0;
    m_vout = 1'b0;
    m_fill = 0;
    RST_n  = 1'b0;
    VIN    = 1'b0;
    DIN    = '0;
    CLR    = 1'b0;
    #1;
    chk("init_dout0", 32'(DOUT0), 32'd0);
    chk("init_vout",  32'(VOUT),  32'd0);
    chk("init_fill",  32'(FILL),  32'd0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    RST_n = 1'b1;
    step(1'b0, '0, 1'b0);

    // Basic group 1,2,3
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    step(1'b1, 8'd3, 1'b0);
    step(1'b0, '0, 1'b0);

    // Back-to-back samples 10..18
    for (int i = 10; i <= 18; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, '0, 1'b0);

    // Gaps between samples
    step(1'b1, 8'd5, 1'b0);
    step(1'b0, 8'd77, 1'b0);
    step(1'b0, 8'd78, 1'b0);
    step(1'b1, 8'd6, 1'b0);
    step(1'b0, 8'd79, 1'b0);
    step(1'b1, 8'd7, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // Clear in P2 with a valid sample: nothing emitted, realign
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    step(1'b1, 8'd9, 1'b1);
    step(1'b1, 8'd4, 1'b0);
    step(1'b1, 8'd5, 1'b0);
    step(1'b1, 8'd6, 1'b0);
    step(1'b0, '0, 1'b0);

    // Reset mid-group
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    do_reset();
    step(1'b1, 8'd7, 1'b0);
    step(1'b1, 8'd8, 1'b0);
    step(1'b1, 8'd9, 1'b0);
    step(1'b0, '0, 1'b0);

    // Signed extremes, bit-exact
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h7F, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, '0, 1'b0);

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
             8'($urandom),
             ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
      end
    end

    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("scoreboard_empty", 32'(m_exp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fir_unfolded_input_packer
`default_nettype wire
